// File: rtl/regfile_op_sequencer.sv
// Multi-cycle register-to-register operation sequencer driving a 4-entry register file.
// Each accepted request walks IDLE -> READ -> EXEC -> WB, one state per clock.
module regfile_op_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_ra,
  input  logic [AW-1:0]    in_rb,
  input  logic [AW-1:0]    in_rd,
  output logic [AW-1:0]    rf_addr1,
  output logic [AW-1:0]    rf_addr2,
  input  logic [WIDTH-1:0] rf_data1,
  input  logic [WIDTH-1:0] rf_data2,
  output logic [AW-1:0]    rf_addr3,
  output logic [WIDTH-1:0] rf_data3,
  output logic             rf_wr,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  localparam int unsigned SW = WIDTH + 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_CMP  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             in_ready_q;
  logic [AW-1:0]    rf_addr1_q;
  logic [AW-1:0]    rf_addr2_q;
  logic [AW-1:0]    rf_addr3_q;
  logic [WIDTH-1:0] rf_data3_q;
  logic             rf_wr_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;

  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic [SW-1:0]    alu_sum;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_carry_d;

  assign in_ready = in_ready_q;
  assign rf_addr1 = rf_addr1_q;
  assign rf_addr2 = rf_addr2_q;
  assign rf_addr3 = rf_addr3_q;
  assign rf_data3 = rf_data3_q;
  assign rf_wr    = rf_wr_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;

  // ALU on the captured operands; SUB and CMP share the A + ~B + 1 adder path
  always_comb begin
    alu_b       = opb_q;
    alu_cin     = 1'b0;
    if (op_q == OP_SUB || op_q == OP_CMP) begin
      alu_b   = ~opb_q;
      alu_cin = 1'b1;
    end
    alu_sum     = SW'(opa_q) + SW'(alu_b) + SW'(alu_cin);
    alu_res_d   = alu_sum[WIDTH-1:0];
    alu_carry_d = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_CMP: begin
        alu_res_d   = alu_sum[WIDTH-1:0];
        alu_carry_d = alu_sum[WIDTH];
      end
      OP_AND:  alu_res_d = opa_q & opb_q;
      OP_OR:   alu_res_d = opa_q | opb_q;
      OP_XOR:  alu_res_d = opa_q ^ opb_q;
      OP_SLT:  alu_res_d = WIDTH'(($signed(opa_q) < $signed(opb_q)) ? 1'b1 : 1'b0);
      OP_PASS: alu_res_d = opa_q;
      default: alu_res_d = alu_sum[WIDTH-1:0];
    endcase
  end

  // Sequencer FSM with registered outputs; reset clears rf_wr/done immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      rd_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      in_ready_q <= 1'b1;
      rf_addr1_q <= '0;
      rf_addr2_q <= '0;
      rf_addr3_q <= '0;
      rf_data3_q <= '0;
      rf_wr_q    <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      carry_q    <= 1'b0;
    end else begin
      rf_wr_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= in_op;
            rd_q       <= in_rd;
            rf_addr1_q <= in_ra;
            rf_addr2_q <= in_rb;
            in_ready_q <= 1'b0;
            state_q    <= READ;
          end
        end
        READ: begin
          opa_q   <= rf_data1;
          opb_q   <= rf_data2;
          state_q <= EXEC;
        end
        EXEC: begin
          result_q   <= alu_res_d;
          zero_q     <= (alu_res_d == '0);
          carry_q    <= alu_carry_d;
          rf_data3_q <= alu_res_d;
          rf_addr3_q <= rd_q;
          rf_wr_q    <= (op_q != OP_CMP);
          done_q     <= 1'b1;
          state_q    <= WB;
        end
        WB: begin
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench for regfile_op_sequencer with a behavioural 4x32 register file.
module tb_regfile_op_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_ra, in_rb, in_rd;
  logic [1:0]  rf_addr1, rf_addr2, rf_addr3;
  logic [31:0] rf_data1, rf_data2, rf_data3;
  logic        rf_wr, done, zero, carry;
  logic [31:0] result;

  logic [31:0] rf [4];
  logic        pl_we;
  logic [1:0]  pl_addr;
  logic [31:0] pl_data;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        wr;
    logic [1:0]  rd;
    int unsigned t;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned xfer_log[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned done_cnt;
  int unsigned wr_cnt;

  regfile_op_sequencer #(.WIDTH(32), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_addr3(rf_addr3), .rf_data3(rf_data3), .rf_wr(rf_wr),
    .done(done), .result(result), .zero(zero), .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_data1 = rf[rf_addr1];
  assign rf_data2 = rf[rf_addr2];

  // Register file: DUT write port has priority over the bench preload port
  always @(posedge clk) begin
    if (rf_wr) rf[rf_addr3] <= rf_data3;
    else if (pl_we) rf[pl_addr] <= pl_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one operation: {carry, result}
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    logic [31:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      3'd0: begin wide = 64'(a) + 64'(b); r = wide[31:0]; c = (wide > 64'hFFFF_FFFF); end
      3'd1, 3'd7: begin r = a - b; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = a;
    endcase
    return {c, r};
  endfunction

  // Transfer monitor: push the expected outcome at the accepting edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && in_valid && in_ready) begin
      exp_t e;
      logic [32:0] m;
      m    = model(in_op, rf[in_ra], rf[in_rb]);
      e.res = m[31:0];
      e.c   = m[32];
      e.z   = (m[31:0] == 32'd0);
      e.wr  = (in_op != 3'd7);
      e.rd  = in_rd;
      e.t   = cyc;
      exp_q.push_back(e);
      xfer_log.push_back(cyc);
    end
  end

  // Completion monitor: pop and compare when done pulses
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("zero", 64'(zero), 64'(e.z));
        check("carry", 64'(carry), 64'(e.c));
        check("rf_wr", 64'(rf_wr), 64'(e.wr));
        check("latency", 64'(cyc - e.t), 64'd3);
        if (e.wr) begin
          check("wr_addr", 64'(rf_addr3), 64'(e.rd));
          check("wr_data", 64'(rf_data3), 64'(e.res));
        end
      end
    end else if (rf_wr) begin
      check("wr_without_done", 64'd1, 64'd0);
    end
    if (rf_wr) wr_cnt++;
  end

  task automatic preload(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b1; in_op = op; in_ra = ra; in_rb = rb; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("idle_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int unsigned base, wc, dc;
    int n;
    n_checks = 0; n_errors = 0; done_cnt = 0; wr_cnt = 0; cyc = 0;
    rst = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_ra = 2'd0; in_rb = 2'd0; in_rd = 2'd0;
    pl_we = 1'b0; pl_addr = 2'd0; pl_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rf_wr", 64'(rf_wr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addrs", 64'({rf_addr1, rf_addr2, rf_addr3}), 64'd0);
    check("rst_data3", 64'(rf_data3), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_carry", 64'(carry), 64'd0);
    rst = 1'b1;

    // Reset mid-EXEC: ADD r0,r1->r2 aborted
    preload(2'd0, 32'd1);
    preload(2'd1, 32'd2);
    preload(2'd2, 32'hCAFE_F00D);
    dc = done_cnt; wc = wr_cnt;
    send(3'd0, 2'd0, 2'd1, 2'd2);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_done", 64'(done_cnt - dc), 64'd0);
    check("abort_wr", 64'(wr_cnt - wc), 64'd0);
    check("abort_r2", 64'(rf[2]), 64'hCAFE_F00D);
    check("abort_ready", 64'(in_ready), 64'd1);

    // ADD overflow
    preload(2'd2, 32'hFFFF_FFFF);
    preload(2'd3, 32'h0000_0001);
    send(3'd0, 2'd2, 2'd3, 2'd0);
    wait_idle();
    check("add_r0", 64'(rf[0]), 64'd0);
    check("add_flags", 64'({zero, carry}), 64'b11);

    // SUB with borrow
    preload(2'd0, 32'h1234_5678);
    preload(2'd1, 32'h9ABC_DEF0);
    send(3'd1, 2'd0, 2'd1, 2'd3);
    wait_idle();
    check("sub_r3", 64'(rf[3]), 64'h7777_7788);
    check("sub_flags", 64'({zero, carry}), 64'b00);

    // CMP: flags update, no write
    wc = wr_cnt;
    send(3'd7, 2'd1, 2'd1, 2'd1);
    wait_idle();
    check("cmp_result", 64'(result), 64'd0);
    check("cmp_flags", 64'({zero, carry}), 64'b11);
    check("cmp_no_wr", 64'(wr_cnt - wc), 64'd0);
    check("cmp_r1", 64'(rf[1]), 64'h9ABC_DEF0);

    // Back-to-back with in_valid held: XOR r2,r2->r2 then SLT r0,r1->r3
    preload(2'd2, 32'hFFFF_FFFF);
    base = 32'(xfer_log.size());
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd4; in_ra = 2'd2; in_rb = 2'd2; in_rd = 2'd2;
    @(negedge clk);
    in_op = 3'd5; in_ra = 2'd0; in_rb = 2'd1; in_rd = 2'd3;
    n = 0;
    while (xfer_log.size() < base + 2 && n < 20) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    if (xfer_log.size() >= base + 2)
      check("b2b_spacing", 64'(xfer_log[base+1] - xfer_log[base]), 64'd4);
    else
      check("b2b_timeout", 64'd0, 64'd1);
    wait_idle();
    check("xor_r2", 64'(rf[2]), 64'd0);
    check("slt_r3", 64'(rf[3]), 64'd0);

    // Handshake hold-off: inputs changing mid-operation are ignored
    preload(2'd0, 32'd5);
    preload(2'd1, 32'd7);
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_ra = 2'd0; in_rb = 2'd1; in_rd = 2'd2;
    @(negedge clk);
    in_valid = 1'b0; in_op = 3'd4; in_ra = 2'd1;
    check("ready_read", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_op = 3'd2; in_ra = 2'd3;
    check("ready_exec", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("ready_wb", 64'(in_ready), 64'd0);
    check("wb_done", 64'(done), 64'd1);
    wait_idle();
    check("hold_r2", 64'(rf[2]), 64'd12);

    // Random operations through the scoreboard
    for (int i = 0; i < 8; i++) begin
      preload(2'($urandom_range(0, 3)), $urandom);
      send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      wait_idle();
    end
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Multi-cycle initiator that drives the 4-entry, 32-bit register file.
- Accepts one register-to-register operation per handshake (op, ra, rb, rd).
- Drives the two asynchronous read ports, captures both operands, computes the result in an internal ALU, then writes it back through the synchronous write port.
- Sits between the instruction/test source and the register file. It is the master side of the regfile read/write interface.

Parameters:
- WIDTH, 32, data word width; must match register file word size.
- AW, 2, register address width (4 registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  sequencer can accept a request.
- in_op  input  3  opcode.
- in_ra  input  AW  source A register.
- in_rb  input  AW  source B register.
- in_rd  input  AW  destination register.
- rf_addr1  output  AW  regfile read address 1.
- rf_addr2  output  AW  regfile read address 2.
- rf_data1  input  WIDTH  regfile read data 1 (combinational from rf_addr1).
- rf_data2  input  WIDTH  regfile read data 2.
- rf_addr3  output  AW  regfile write address.
- rf_data3  output  WIDTH  regfile write data.
- rf_wr  output  1  regfile write enable.
- done  output  1  one-cycle pulse when an operation completes.
- result  output  WIDTH  last computed result; held until next completion.
- zero  output  1  result == 0; updated with result.
- carry  output  1  carry-out of ADD/SUB; 0 for other ops.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - Outputs: in_ready=1; rf_wr=0; done=0; rf_addr1/2/3=0; rf_data3=0; result=0; zero=1; carry=0.
  - rf_wr drops immediately, even mid-operation. The aborted op is discarded with no write and no done.
- Handshake:
  - Transfer occurs on a rising edge with in_valid & in_ready.
  - in_ready=1 only in IDLE.
  - Request fields are registered at transfer; later changes to inputs are ignored.
- FSM (state advances every clock, no stalls):
  - IDLE -> READ on transfer.
  - READ: rf_addr1=ra, rf_addr2=rb (registered). At the end of READ, rf_data1/rf_data2 are captured into opA/opB.
  - EXEC: compute from opA/opB. Register the result into rf_data3, rf_addr3=rd, result, zero, carry.
  - WB: rf_wr=1 for exactly this cycle if the op writes back; done=1 for this cycle. Next state is IDLE.
- Latency: transfer edge T -> done high during cycle T+3. The regfile is updated at edge T+3.
- Throughput: one op per 4 cycles. in_ready rises in the cycle after WB, so back-to-back requests are accepted at T+4.
- Opcodes:
  - 0 ADD: A+B; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 1 SUB: A+~B+1; carry = carry-out (1 means no borrow, i.e. A>=B unsigned).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLT: signed A<B -> 1, else 0.
  - 6 PASS: A.
  - 7 CMP: computes SUB and updates result/zero/carry, but rf_wr stays 0 (done still pulses).
- Arithmetic is modulo 2^WIDTH.
- Aliasing: ra==rb, rd==ra, or rd==rb are legal. Operands are captured before the write, so the old value is used.
- rf_addr1/2 hold their last value outside READ. rf_addr3/rf_data3 hold outside WB. The regfile only observes them when rf_wr=1.
- Reset applied during WB: no write occurs (rf_wr is forced low asynchronously before the edge).

Test Plan:
- Reset mid-EXEC: assert rst=0 during EXEC of an ADD r0,r1->r2 -> rf_wr never asserts, done never pulses, r2 is unchanged, in_ready=1 after release.
- ADD overflow: preload r2=FFFFFFFF, r3=00000001; op=0, ra=2, rb=3, rd=0 -> done at T+3, result=00000000, zero=1, carry=1, r0=00000000.
- SUB with borrow: preload r0=12345678, r1=9ABCDEF0; op=1, ra=0, rb=1, rd=3 -> result=77777788, carry=0, zero=0, r3=77777788.
- CMP no write: r1=9ABCDEF0; op=7, ra=1, rb=1, rd=1 -> result=0, zero=1, carry=1, rf_wr stays 0, r1 is unchanged.
- Aliasing and back-to-back: in_valid held high with XOR r2,r2->r2 (r2=FFFFFFFF) then SLT r0,r1->r3 (r0=12345678, r1=9ABCDEF0):
  - Second request is accepted exactly 4 cycles after the first.
  - r2=00000000.
  - r3=00000000 (positive value is not < negative value).
- Handshake hold-off: change in_ra/in_op while in READ/EXEC -> no effect on the result; in_ready=0 in READ, EXEC and WB.
